// File: rtl/load_store_unit.sv
// Load/store unit: turns one decoded load or store into a single word-aligned bus
// transaction, extends load data, and stalls the core until the access completes.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_we,
   input  logic        mem_reg_w,
   input  logic [2:0]  mem_re,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        misaligned_err,
   output logic        bus_err,
   output logic        bus_valid,
   input  logic        bus_ready,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [1:0]        off_q, off_d;
   logic [2:0]        size_q, size_d;
   logic              we_q, we_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       load_q, load_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic              access, is_byte, is_half, misaligned;
   logic [3:0]        be_new;
   logic [31:0]       wdata_new, load_ext;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;

   // Reserved size codes fall through to word handling.
   assign access     = mem_we | mem_reg_w;
   assign is_byte    = (mem_re[1:0] == 2'b00);
   assign is_half    = (mem_re[1:0] == 2'b01);
   assign misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = store_data;
      if (is_byte) begin
         be_new    = 4'b0001 << addr[1:0];
         wdata_new = {4{store_data[7:0]}};
      end else if (is_half) begin
         be_new    = 4'b0011 << addr[1:0];
         wdata_new = {2{store_data[15:0]}};
      end
   end

   always_comb begin
      rd_byte  = 8'(bus_rdata >> {off_q, 3'b000});
      rd_half  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      load_ext = bus_rdata;
      if (size_q[1:0] == 2'b00) begin
         load_ext = size_q[2] ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      end else if (size_q[1:0] == 2'b01) begin
         load_ext = size_q[2] ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      end
   end

   always_comb begin
      state_d        = state_q;
      off_d          = off_q;
      size_d         = size_q;
      we_d           = we_q;
      be_d           = be_q;
      wdata_d        = wdata_q;
      addr_d         = addr_q;
      load_d         = load_q;
      cnt_d          = cnt_q;
      stall          = 1'b0;
      misaligned_err = 1'b0;
      bus_err        = 1'b0;
      bus_valid      = 1'b0;
      case (state_q)
         StIdle: begin
            if (access) begin
               if (misaligned) begin
                  misaligned_err = 1'b1;
               end else begin
                  stall   = 1'b1;
                  off_d   = addr[1:0];
                  size_d  = mem_re;
                  we_d    = mem_we;
                  be_d    = be_new;
                  wdata_d = wdata_new;
                  addr_d  = {addr[31:2], 2'b00};
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            bus_valid = 1'b1;
            stall     = 1'b1;
            if (bus_ready) begin
               cnt_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
            stall = 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (bus_rvalid) begin
               if (!we_q) load_d = load_ext;
               state_d = StDone;
            end else if (TIMEOUT != 0 && cnt_q == CntW'(TIMEOUT - 1)) begin
               bus_err = 1'b1;
               if (!we_q) load_d = '0;
               state_d = StDone;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         off_q   <= '0;
         size_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         load_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         size_q  <= size_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
      end
   end

   assign load_data = load_q;
   assign bus_we    = we_q;
   assign bus_addr  = addr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_we, mem_reg_w;
   logic [2:0]  mem_re;
   logic [31:0] addr, store_data;
   logic [31:0] load_data;
   logic        stall, misaligned_err, bus_err, bus_valid, bus_ready, bus_we, bus_rvalid;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_we         (mem_we),
      .mem_reg_w      (mem_reg_w),
      .mem_re         (mem_re),
      .addr           (addr),
      .store_data     (store_data),
      .load_data      (load_data),
      .stall          (stall),
      .misaligned_err (misaligned_err),
      .bus_err        (bus_err),
      .bus_valid      (bus_valid),
      .bus_ready      (bus_ready),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_be         (bus_be),
      .bus_wdata      (bus_wdata),
      .bus_rvalid     (bus_rvalid),
      .bus_rdata      (bus_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full access; hold = cycles bus_ready stays low in REQ.
   task automatic xfer(input logic st, input logic [2:0] re, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int hold,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
      mem_we     = st;
      mem_reg_w  = !st;
      mem_re     = re;
      addr       = a;
      store_data = sd;
      bus_rdata  = rd;
      bus_ready  = 1'b0;
      #1;
      chk("idle_stall", 32'(stall), 32'd1);
      tick();
      chk("req_valid", 32'(bus_valid), 32'd1);
      chk("req_addr", bus_addr, {a[31:2], 2'b00});
      chk("req_we", 32'(bus_we), 32'(st));
      if (st) begin
         chk("req_be", 32'(bus_be), 32'(exp_be));
         chk("req_wdata", bus_wdata, exp_wd);
      end
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_valid", 32'(bus_valid), 32'd1);
         chk("hold_addr", bus_addr, {a[31:2], 2'b00});
         chk("hold_stall", 32'(stall), 32'd1);
      end
      bus_ready = 1'b1;
      tick();
      bus_ready = 1'b0;
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_valid", 32'(bus_valid), 32'd0);
      bus_rvalid = 1'b1;
      tick();
      bus_rvalid = 1'b0;
      chk("done_stall", 32'(stall), 32'd0);
      mem_we    = 1'b0;
      mem_reg_w = 1'b0;
      tick();
   endtask

   task automatic misal(input logic st, input logic [2:0] re, input logic [31:0] a);
      mem_we    = st;
      mem_reg_w = !st;
      mem_re    = re;
      addr      = a;
      #1;
      chk("mis_err", 32'(misaligned_err), 32'd1);
      chk("mis_stall", 32'(stall), 32'd0);
      chk("mis_valid", 32'(bus_valid), 32'd0);
      tick();
      chk("mis_valid2", 32'(bus_valid), 32'd0);
      mem_we    = 1'b0;
      mem_reg_w = 1'b0;
      #1;
      chk("mis_clear", 32'(misaligned_err), 32'd0);
      tick();
   endtask

   initial begin
      rst        = 1'b1;
      mem_we     = 1'b0;
      mem_reg_w  = 1'b0;
      mem_re     = 3'b000;
      addr       = '0;
      store_data = '0;
      bus_ready  = 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      tick();
      tick();
      chk("rst_load", load_data, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_valid", 32'(bus_valid), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_be", 32'(bus_be), 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_we", 32'(bus_we), 32'd0);
      chk("rst_errs", 32'({misaligned_err, bus_err}), 32'd0);
      rst        = 1'b0;
      bus_rdata  = 32'hFFFF_FFFF;
      bus_rvalid = 1'b1;
      tick();
      bus_rvalid = 1'b0;
      tick();
      chk("idle_rvalid_load", load_data, 32'd0);

      // SB to top byte lane
      xfer(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0, 4'b1000, 32'hDDDD_DDDD);
      chk("sb_load_kept", load_data, 32'd0);

      xfer(1'b0, 3'b000, 32'h0000_2001, 32'h0, 32'h1234_F680, 0, 4'b0, 32'h0);
      chk("lb", load_data, 32'hFFFF_FFF6);
      xfer(1'b0, 3'b100, 32'h0000_2001, 32'h0, 32'h1234_F680, 0, 4'b0, 32'h0);
      chk("lbu", load_data, 32'h0000_00F6);
      xfer(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'h1234_F680, 0, 4'b0, 32'h0);
      chk("lhu", load_data, 32'h0000_1234);
      xfer(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8765_0000, 0, 4'b0, 32'h0);
      chk("lh", load_data, 32'hFFFF_8765);
      xfer(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1234_F680, 0, 4'b0, 32'h0);
      chk("lw", load_data, 32'h1234_F680);

      // LW with bus_ready held low for 5 cycles
      xfer(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'hCAFE_BABE, 5, 4'b0, 32'h0);
      chk("lw_hold", load_data, 32'hCAFE_BABE);

      xfer(1'b1, 3'b001, 32'h0000_2002, 32'h1122_3344, 32'h0, 0, 4'b1100, 32'h3344_3344);
      xfer(1'b1, 3'b010, 32'h0000_2008, 32'h5566_7788, 32'h0, 0, 4'b1111, 32'h5566_7788);
      chk("store_keeps_load", load_data, 32'hCAFE_BABE);

      misal(1'b0, 3'b001, 32'h0000_3001);
      misal(1'b1, 3'b010, 32'h0000_3002);
      misal(1'b0, 3'b110, 32'h0000_3001);
      chk("mis_load_kept", load_data, 32'hCAFE_BABE);

      // Load timeout: no rvalid, TIMEOUT=4
      mem_reg_w = 1'b1;
      mem_re    = 3'b010;
      addr      = 32'h0000_4000;
      bus_ready = 1'b1;
      tick();
      tick();
      bus_ready = 1'b0;
      chk("to_w1_err", 32'(bus_err), 32'd0);
      tick();
      tick();
      chk("to_w3_err", 32'(bus_err), 32'd0);
      tick();
      chk("to_w4_err", 32'(bus_err), 32'd1);
      chk("to_w4_stall", 32'(stall), 32'd1);
      tick();
      chk("to_done_err", 32'(bus_err), 32'd0);
      chk("to_done_stall", 32'(stall), 32'd0);
      chk("to_load", load_data, 32'd0);
      mem_reg_w = 1'b0;
      tick();

      // Reset while in REQ
      mem_reg_w = 1'b1;
      mem_re    = 3'b010;
      addr      = 32'h0000_5000;
      bus_rdata = 32'h1357_9BDF;
      tick();
      chk("rq_valid", 32'(bus_valid), 32'd1);
      rst       = 1'b1;
      mem_reg_w = 1'b0;
      tick();
      chk("rr_valid", 32'(bus_valid), 32'd0);
      chk("rr_stall", 32'(stall), 32'd0);
      rst        = 1'b0;
      bus_rvalid = 1'b1;
      tick();
      bus_rvalid = 1'b0;
      tick();
      chk("rr_late_rvalid", load_data, 32'd0);
      chk("rr_idle_valid", 32'(bus_valid), 32'd0);

      // Unit still works after reset
      xfer(1'b0, 3'b000, 32'h0000_6003, 32'h0, 32'h7F00_0000, 0, 4'b0, 32'h0);
      chk("post_rst_lb", load_data, 32'h0000_007F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule
